// File: rtl/prbs_error_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs_error_checker
// Description : Self-synchronising PRBS checker. Builds a history of the
//               received stream, verifies predictions for the selected PN
//               polynomial, then free-runs the reference while counting
//               compared bits and bit errors. Drops lock when too many errors
//               land in one monitor window.
// Ports       : dac_clk, reset (async, active-high)
//               bit_in / bit_valid        received bit and its strobe
//               prbs_pn_select[4:0]       0..6 = PN7,9,11,15,20,23,31
//               clear_counters            sync clear of the counters
//               locked, bit_error, lock_lost, sync_state[1:0]
//               error_count[31:0], bit_count[31:0] (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_error_checker #(
  parameter int WIN_LEN     = 128,
  parameter int LOSS_THRESH = 16,
  parameter int VERIFY_LEN  = 32
) (
  input  logic        dac_clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic [4:0]  prbs_pn_select,
  input  logic        clear_counters,
  output logic        locked,
  output logic        bit_error,
  output logic [31:0] error_count,
  output logic [31:0] bit_count,
  output logic        lock_lost,
  output logic [1:0]  sync_state
);

  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam int VW = (VERIFY_LEN > 1) ? $clog2(VERIFY_LEN) : 1;

  localparam logic [WW-1:0] WIN_LAST    = WW'(WIN_LEN - 1);
  localparam logic [EW-1:0] ERR_THRESH  = EW'(LOSS_THRESH);
  localparam logic [VW-1:0] VERIFY_LAST = VW'(VERIFY_LEN - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [30:0]   hist, hist_n;
  logic [4:0]    fill, fill_n;
  logic [VW-1:0] vcnt, vcnt_n;
  logic [WW-1:0] wbit, wbit_n;
  logic [EW-1:0] werr, werr_n;
  logic [31:0]   ecnt_n, bcnt_n;
  logic          err_n, lost_n;
  logic [4:0]    sel_q;

  logic [4:0]    order, tap;
  logic          sel_ok;
  logic          sel_change;
  logic          pred;
  logic          mism;

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Order/tap of the selected polynomial. Invalid selects fall back to a
  // legal order so the history index below never leaves h[30:0].
  always_comb begin
    sel_ok = 1'b1;
    order  = 5'd7;
    tap    = 5'd6;
    case (prbs_pn_select)
      5'd0: begin order = 5'd7;  tap = 5'd6;  end
      5'd1: begin order = 5'd9;  tap = 5'd5;  end
      5'd2: begin order = 5'd11; tap = 5'd9;  end
      5'd3: begin order = 5'd15; tap = 5'd14; end
      5'd4: begin order = 5'd20; tap = 5'd3;  end
      5'd5: begin order = 5'd23; tap = 5'd18; end
      5'd6: begin order = 5'd31; tap = 5'd28; end
      default: sel_ok = 1'b0;
    endcase
  end

  // b[n] = b[n-N] ^ b[n-T], with hist[0] holding b[n-1].
  assign pred       = hist[order - 5'd1] ^ hist[tap - 5'd1];
  assign mism       = bit_in ^ pred;
  assign sel_change = (prbs_pn_select != sel_q);

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    vcnt_n  = vcnt;
    wbit_n  = wbit;
    werr_n  = werr;
    ecnt_n  = error_count;
    bcnt_n  = bit_count;
    err_n   = 1'b0;
    lost_n  = 1'b0;

    if (sel_change || !sel_ok) begin
      state_n = ST_SEARCH;
      fill_n  = 5'd0;
    end else if (bit_valid) begin
      case (state)
        ST_SEARCH: begin
          hist_n = {hist[29:0], bit_in};
          fill_n = fill + 5'd1;
          if (fill_n == order) begin
            state_n = ST_VERIFY;
            vcnt_n  = '0;
          end
        end
        ST_VERIFY: begin
          hist_n = {hist[29:0], bit_in};
          if (!mism) begin
            if (vcnt == VERIFY_LAST) begin
              state_n = ST_LOCKED;
              wbit_n  = '0;
              werr_n  = '0;
            end else begin
              vcnt_n = vcnt + VW'(1);
            end
          end else begin
            // History is still a valid stream; one more bit re-arms VERIFY.
            state_n = ST_SEARCH;
            fill_n  = order - 5'd1;
          end
        end
        ST_LOCKED: begin
          // Free-running reference: a line error never enters the history.
          hist_n = {hist[29:0], pred};
          bcnt_n = sat_inc(bit_count);
          wbit_n = wbit + WW'(1);
          if (wbit == WIN_LAST)
            werr_n = mism ? EW'(1) : '0;
          else
            werr_n = werr + EW'(mism);
          if (mism) begin
            err_n  = 1'b1;
            ecnt_n = sat_inc(error_count);
          end
          if (werr_n == ERR_THRESH) begin
            state_n = ST_SEARCH;
            fill_n  = 5'd0;
            lost_n  = 1'b1;
          end
        end
        default: begin
          state_n = ST_SEARCH;
          fill_n  = 5'd0;
        end
      endcase
    end

    if (clear_counters) begin
      ecnt_n = '0;
      bcnt_n = '0;
    end
  end

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_SEARCH;
      hist        <= '0;
      fill        <= '0;
      vcnt        <= '0;
      wbit        <= '0;
      werr        <= '0;
      sel_q       <= '0;
      error_count <= '0;
      bit_count   <= '0;
      bit_error   <= 1'b0;
      lock_lost   <= 1'b0;
      locked      <= 1'b0;
      sync_state  <= 2'd0;
    end else begin
      state       <= state_n;
      hist        <= hist_n;
      fill        <= fill_n;
      vcnt        <= vcnt_n;
      wbit        <= wbit_n;
      werr        <= werr_n;
      sel_q       <= prbs_pn_select;
      error_count <= ecnt_n;
      bit_count   <= bcnt_n;
      bit_error   <= err_n;
      lock_lost   <= lost_n;
      locked      <= (state_n == ST_LOCKED);
      sync_state  <= state_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs_error_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_error_checker
// Description : Directed self-checking bench for prbs_error_checker. A local
//               PN generator drives the stream; selected bits are inverted to
//               model line errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_error_checker;

  logic        dac_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        bit_in  = 1'b0;
  logic        bit_valid = 1'b0;
  logic [4:0]  prbs_pn_select = 5'd0;
  logic        clear_counters = 1'b0;
  logic        locked, bit_error, lock_lost;
  logic [31:0] error_count, bit_count;
  logic [1:0]  sync_state;

  prbs_error_checker dut (
    .dac_clk        (dac_clk),
    .reset          (reset),
    .bit_in         (bit_in),
    .bit_valid      (bit_valid),
    .prbs_pn_select (prbs_pn_select),
    .clear_counters (clear_counters),
    .locked         (locked),
    .bit_error      (bit_error),
    .error_count    (error_count),
    .bit_count      (bit_count),
    .lock_lost      (lock_lost),
    .sync_state     (sync_state)
  );

  always #5 dac_clk = ~dac_clk;

  int total = 0;
  int bad   = 0;

  // Reference generator state
  logic [30:0] g;
  int gord, gtap;

  // Per-segment observations
  int nvalid, nerr, nlost, lock_at;
  bit seen_lock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic b, input logic v);
    bit_in    = b;
    bit_valid = v;
    @(posedge dac_clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic set_gen(input int ord, input int tp);
    gord = ord;
    gtap = tp;
  endtask

  task automatic gen(output logic b);
    b = g[gord-1] ^ g[gtap-1];
    g = {g[29:0], b};
  endtask

  task automatic start_seg();
    nvalid    = 0;
    nerr      = 0;
    nlost     = 0;
    lock_at   = 0;
    seen_lock = locked;
  endtask

  task automatic send_one(input bit flip, input int gap);
    logic b;
    gen(b);
    cyc(b ^ flip, 1'b1);
    nvalid++;
    if (bit_error) nerr++;
    if (lock_lost) nlost++;
    if (locked && !seen_lock) begin
      seen_lock = 1'b1;
      lock_at   = nvalid;
    end
    repeat (gap) cyc(1'b0, 1'b0);
  endtask

  // Two idle cycles after release absorb the select-change seen against the
  // reset value of the registered select.
  task automatic do_reset();
    g = 31'h2AAA_5555;
    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b0);
  endtask

  initial begin
    // ---- PN7, back-to-back strobes ----
    prbs_pn_select = 5'd0;
    set_gen(7, 6);
    do_reset();
    chk("rst_locked",    {31'd0, locked},     32'd0);
    chk("rst_sync",      {30'd0, sync_state}, 32'd0);
    chk("rst_errcnt",    error_count,         32'd0);
    chk("rst_bitcnt",    bit_count,           32'd0);
    chk("rst_biterr",    {31'd0, bit_error},  32'd0);
    chk("rst_locklost",  {31'd0, lock_lost},  32'd0);
    start_seg();
    repeat (39) send_one(1'b0, 0);
    chk("pn7_lock_at",   lock_at, 32'd39);
    chk("pn7_sync",      {30'd0, sync_state}, 32'd2);
    start_seg();
    repeat (1000) send_one(1'b0, 0);
    chk("pn7_errcnt",    error_count, 32'd0);
    chk("pn7_bitcnt",    bit_count,   32'd1000);
    chk("pn7_locked",    {31'd0, locked}, 32'd1);

    // ---- PN31, 1-in-4 strobes, one flipped bit ----
    prbs_pn_select = 5'd6;
    set_gen(31, 28);
    do_reset();
    start_seg();
    repeat (63) send_one(1'b0, 3);
    chk("pn31_lock_at",  lock_at, 32'd63);
    start_seg();
    for (int i = 0; i < 50; i++) send_one(i == 20, 3);
    chk("pn31_pulses",   nerr, 32'd1);
    chk("pn31_errcnt",   error_count, 32'd1);
    chk("pn31_locked",   {31'd0, locked}, 32'd1);
    chk("pn31_nolost",   nlost, 32'd0);

    // ---- PN15, 16 errors in one window -> loss of lock, then relock ----
    prbs_pn_select = 5'd3;
    set_gen(15, 14);
    do_reset();
    start_seg();
    repeat (47) send_one(1'b0, 0);
    chk("pn15_lock_at",  lock_at, 32'd47);
    start_seg();
    for (int i = 0; i < 26; i++) send_one(i >= 10, 0);
    chk("loss_pulse_now", {31'd0, lock_lost}, 32'd1);
    chk("loss_sync",     {30'd0, sync_state}, 32'd0);
    chk("loss_npulses",  nlost, 32'd1);
    chk("loss_nerr",     nerr, 32'd16);
    chk("loss_errcnt",   error_count, 32'd16);
    start_seg();
    repeat (47) send_one(1'b0, 0);
    chk("relock_at",     lock_at, 32'd47);
    chk("relock_errcnt", error_count, 32'd16);

    // ---- PN15, 15 errors in each of two windows -> stays locked ----
    do_reset();
    start_seg();
    repeat (47) send_one(1'b0, 0);
    start_seg();
    for (int i = 0; i < 256; i++)
      send_one((i >= 10 && i < 25) || (i >= 140 && i < 155), 0);
    chk("win2_locked",   {31'd0, locked}, 32'd1);
    chk("win2_errcnt",   error_count, 32'd30);
    chk("win2_nolost",   nlost, 32'd0);
    chk("win2_bitcnt",   bit_count, 32'd256);

    // ---- PN9 locked, switch to PN23 ----
    prbs_pn_select = 5'd1;
    set_gen(9, 5);
    do_reset();
    start_seg();
    repeat (41) send_one(1'b0, 0);
    chk("pn9_lock_at",   lock_at, 32'd41);
    prbs_pn_select = 5'd5;
    cyc(1'b0, 1'b0);
    chk("sw_locked",     {31'd0, locked}, 32'd0);
    chk("sw_nolost",     {31'd0, lock_lost}, 32'd0);
    chk("sw_sync",       {30'd0, sync_state}, 32'd0);
    set_gen(23, 18);
    start_seg();
    repeat (55) send_one(1'b0, 0);
    chk("pn23_lock_at",  lock_at, 32'd55);

    // ---- clear_counters beats a simultaneous error ----
    clear_counters = 1'b1;
    send_one(1'b1, 0);
    clear_counters = 1'b0;
    chk("clr_errcnt",    error_count, 32'd0);
    chk("clr_bitcnt",    bit_count,   32'd0);
    chk("clr_biterr",    {31'd0, bit_error}, 32'd1);
    send_one(1'b1, 0);
    chk("post_clr_err",  error_count, 32'd1);
    chk("post_clr_bits", bit_count,   32'd1);

    // ---- asynchronous reset mid-LOCKED, checked before any clock edge ----
    reset = 1'b1;
    #2;
    chk("arst_locked",   {31'd0, locked}, 32'd0);
    chk("arst_errcnt",   error_count, 32'd0);
    chk("arst_bitcnt",   bit_count,   32'd0);
    chk("arst_biterr",   {31'd0, bit_error}, 32'd0);
    chk("arst_sync",     {30'd0, sync_state}, 32'd0);
    reset = 1'b0;
    cyc(1'b0, 1'b0);

    // ---- invalid select holds SEARCH ----
    prbs_pn_select = 5'd7;
    set_gen(7, 6);
    do_reset();
    start_seg();
    repeat (60) send_one(1'b0, 0);
    chk("inv_sync",      {30'd0, sync_state}, 32'd0);
    chk("inv_locked",    {31'd0, locked}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs_error_checker.md
# prbs_error_checker

Receive-side counterpart of the PRBS generator chain. Takes a serial PRBS bit stream qualified by a bit-rate strobe and self-synchronises a local reference to the selected PN polynomial. Once locked, it counts compared bits and bit errors and flags loss of lock. Used for loopback BER measurement and for self-test of the generator path in the dac_clk domain.

## Interface
- WIN_LEN, 128: locked-state error-monitor window length in valid bits (power of 2).
- LOSS_THRESH, 16: errors within one window that force loss of lock.
- VERIFY_LEN, 32: consecutive correct predictions required to declare lock.
- dac_clk  in  1  sole clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- bit_in  in  1  received PRBS bit; sampled only when bit_valid=1.
- bit_valid  in  1  bit strobe, at most one per cycle (same role as lfsr_clk_enable).
- prbs_pn_select  in  5  0:PN7 (x^7+x^6+1), 1:PN9 (x^9+x^5+1), 2:PN11 (x^11+x^9+1), 3:PN15 (x^15+x^14+1), 4:PN20 (x^20+x^3+1), 5:PN23 (x^23+x^18+1), 6:PN31 (x^31+x^28+1); 7-31 invalid.
- clear_counters  in  1  synchronous clear of error_count and bit_count.
- locked  out  1  1 while in LOCKED.
- bit_error  out  1  one-cycle pulse per mismatched bit in LOCKED.
- error_count  out  32  saturating bit-error count.
- bit_count  out  32  saturating count of bits compared in LOCKED.
- lock_lost  out  1  one-cycle pulse on LOCKED->SEARCH caused by the error threshold.
- sync_state  out  2  debug: 0 SEARCH, 1 VERIFY, 2 LOCKED.

## Operation
- History register h[30:0]; h[0] is the most recent bit. Order N and tap T come from prbs_pn_select. Predicted bit p = h[N-1] ^ h[T-1], i.e. b[n] = b[n-N] ^ b[n-T]. This rule is independent of the generator's Fibonacci/Galois form.
- SEARCH: each valid bit shifts bit_in into h, and a fill counter increments. When the fill reaches N valid bits, go to VERIFY with the verify counter at 0. An invalid select holds SEARCH with the fill counter at 0.
- VERIFY: each valid bit shifts bit_in into h.
  - If bit_in == p, increment the verify counter.
  - Otherwise go to SEARCH with the fill counter set to N-1. The history is still valid, so a single new bit re-arms VERIFY.
  - On the VERIFY_LEN-th consecutive match, go to LOCKED and clear the window counters.
- LOCKED: each valid bit shifts p (not bit_in) into h. The reference free-runs, so one line error produces exactly one count.
  - Every valid bit increments bit_count.
  - A mismatch pulses bit_error, increments error_count and increments the window error count.
  - The window bit counter wraps at WIN_LEN. The window error count resets on the wrap cycle, unless that same bit is an error, in which case it is set to 1.
  - When the window error count reaches LOSS_THRESH, go to SEARCH with fill 0 and pulse lock_lost.
- Any change of prbs_pn_select (registered compare) forces SEARCH with fill 0 from any state. It does not pulse lock_lost.
- Counters:
  - Saturate at 32'hFFFF_FFFF.
  - clear_counters wins over an increment in the same cycle; the result is 0.
  - Counters are not affected by state changes.
- Bits with bit_valid=0 are ignored. State only advances on valid bits, except for select-change and reset.

## Timing
- Reset values: h=0, state SEARCH, all counters 0, locked=0, bit_error=0, lock_lost=0, sync_state=0.
- Latency: the bit presented with bit_valid in cycle k is reflected in bit_error, error_count, bit_count, locked and lock_lost at cycle k+1. All outputs are registered.
- Lock acquisition with a clean stream takes N+VERIFY_LEN valid bits. locked rises the cycle after that last strobe.
- Select change detected in cycle k drops locked at k+1.
- Asynchronous reset mid-operation clears everything immediately. Reacquisition starts from an empty fill.
- Back-to-back bit_valid every cycle is supported: one bit per cycle, no stalls, no backpressure.

## Test plan
- PN7, clean generator stream, bit_valid every cycle: locked rises after the 39th valid bit. After 1000 further bits, error_count=0 and bit_count=1000.
- PN31, bit_valid 1-in-4: locked after 63 valid bits. One flipped bit gives exactly one bit_error pulse, error_count=1, and locked stays 1.
- PN15 locked, inject 16 errors within one 128-bit window: lock_lost pulses on the 16th error and sync_state=0. With a clean stream the block relocks after 47 valid bits; error_count stays 16.
- PN15 locked, 15 errors in window 1 and 15 in window 2: locked stays 1 and error_count=30.
- Locked on PN9, switch select to PN23: locked=0 at the next cycle with no lock_lost pulse. Relock occurs after 55 PN23 bits.
- clear_counters asserted in the same cycle as an error strobe: error_count=0 afterwards. Assert reset mid-LOCKED: all outputs are 0 in the same cycle, asynchronously.
